// File: rtl/reg_bank4x16.sv
// reg_bank4x16: 4-entry register bank with one write port and two registered read ports (A, B).
// BYPASS selects whether a read that hits the register being written sees the new data or the old data.
module reg_bank4x16 #(
  parameter int WIDTH  = 16,
  parameter bit BYPASS = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [1:0]       i_waddr,
  input  logic [WIDTH-1:0] i_in,
  input  logic             i_ren_a,
  input  logic [1:0]       i_raddr_a,
  output logic [WIDTH-1:0] o_out_a,
  output logic             o_valid_a,
  input  logic             i_ren_b,
  input  logic [1:0]       i_raddr_b,
  output logic [WIDTH-1:0] o_out_b,
  output logic             o_valid_b
);
  logic [WIDTH-1:0] r_mem [4];
  logic [WIDTH-1:0] r_out_a, r_out_b;
  logic             r_valid_a, r_valid_b;
  logic [WIDTH-1:0] w_sel_a, w_sel_b;
  // a same-cycle write to the addressed register forwards its data only when BYPASS is set
  always_comb begin
    w_sel_a = (BYPASS && i_load && i_waddr == i_raddr_a) ? i_in : r_mem[i_raddr_a];
    w_sel_b = (BYPASS && i_load && i_waddr == i_raddr_b) ? i_in : r_mem[i_raddr_b];
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_mem     <= '{default: '0};
      r_out_a   <= '0;
      r_out_b   <= '0;
      r_valid_a <= 1'b0;
      r_valid_b <= 1'b0;
    end else begin
      if (i_load) r_mem[i_waddr] <= i_in;
      if (i_ren_a) r_out_a <= w_sel_a;
      if (i_ren_b) r_out_b <= w_sel_b;
      r_valid_a <= i_ren_a;
      r_valid_b <= i_ren_b;
    end
  end
  assign o_out_a   = r_out_a;
  assign o_out_b   = r_out_b;
  assign o_valid_a = r_valid_a;
  assign o_valid_b = r_valid_b;
endmodule

// File: tb/tb_reg_bank4x16.sv
// tb_reg_bank4x16: directed scenarios plus randomized traffic against an array-based reference model.
module tb_reg_bank4x16;
  localparam bit BYPASS = 1'b1;
  logic clk = 1'b0;
  logic rst_n, load, ren_a, ren_b;
  logic [1:0] waddr, ra_a, ra_b;
  logic [15:0] din;
  logic [15:0] out_a, out_b;
  logic valid_a, valid_b;
  logic [15:0] m [4];
  logic [15:0] eo_a, eo_b;
  logic ev_a, ev_b;
  int total = 0;
  int bad = 0;
  reg_bank4x16 #(.WIDTH(16), .BYPASS(BYPASS)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_load(load), .i_waddr(waddr), .i_in(din),
    .i_ren_a(ren_a), .i_raddr_a(ra_a), .o_out_a(out_a), .o_valid_a(valid_a),
    .i_ren_b(ren_b), .i_raddr_b(ra_b), .o_out_b(out_b), .o_valid_b(valid_b)
  );
  always #5 clk = ~clk;
  task automatic idle();
    rst_n = 1'b1; load = 1'b0; waddr = 2'd0; din = 16'h0;
    ren_a = 1'b0; ra_a = 2'd0; ren_b = 1'b0; ra_b = 2'd0;
  endtask
  task automatic step();
    logic [15:0] sa, sb;
    @(posedge clk);
    if (!rst_n) begin
      m = '{default: 16'h0};
      eo_a = 16'h0; eo_b = 16'h0; ev_a = 1'b0; ev_b = 1'b0;
    end else begin
      sa = (BYPASS && load && waddr == ra_a) ? din : m[ra_a];
      sb = (BYPASS && load && waddr == ra_b) ? din : m[ra_b];
      if (ren_a) eo_a = sa;
      if (ren_b) eo_b = sb;
      ev_a = ren_a;
      ev_b = ren_b;
      if (load) m[waddr] = din;
    end
    #1;
  endtask
  task automatic test_reset();
    idle();
    rst_n = 1'b0; load = 1'b1; ren_a = 1'b1; ren_b = 1'b1; din = 16'hDEAD;
    for (int i = 0; i < 2; i++) begin
      waddr = 2'(i); ra_a = 2'(i); ra_b = 2'(3 - i);
      step();
      total++;
      if ({out_a, valid_a, out_b, valid_b} !== 34'h0) begin
        bad++; $display("FAIL reset cyc%0d: got a=%h va=%b b=%h vb=%b want all 0", i, out_a, valid_a, out_b, valid_b);
      end
    end
    idle();
    for (int i = 0; i < 4; i++) begin
      ren_a = 1'b1; ra_a = 2'(i); ren_b = 1'b1; ra_b = 2'(i);
      step();
      total++;
      if ({out_a, valid_a, out_b, valid_b} !== {16'h0, 1'b1, 16'h0, 1'b1}) begin
        bad++; $display("FAIL reset_read addr%0d: got a=%h va=%b b=%h vb=%b want 0/1", i, out_a, valid_a, out_b, valid_b);
      end
    end
  endtask
  task automatic fill();
    logic [15:0] pat [4] = '{16'hAAAA, 16'h5555, 16'hFFFF, 16'h0000};
    idle();
    for (int i = 0; i < 4; i++) begin
      load = 1'b1; waddr = 2'(i); din = pat[i];
      step();
    end
    idle();
  endtask
  task automatic test_fill_read();
    logic [15:0] pat [4] = '{16'hAAAA, 16'h5555, 16'hFFFF, 16'h0000};
    fill();
    total++;
    if ({valid_a, valid_b} !== 2'b00) begin
      bad++; $display("FAIL fill_valid: got va=%b vb=%b want 0 0", valid_a, valid_b);
    end
    for (int i = 0; i < 4; i++) begin
      ren_a = 1'b1; ra_a = 2'(i);
      step();
      total++;
      if (out_a !== pat[i] || valid_a !== 1'b1 || out_a !== eo_a) begin
        bad++; $display("FAIL fill_read addr%0d: got %h v=%b want %h v=1", i, out_a, valid_a, pat[i]);
      end
    end
    idle();
  endtask
  task automatic test_dual_port();
    idle();
    ren_a = 1'b1; ra_a = 2'd1; ren_b = 1'b1; ra_b = 2'd2;
    step();
    total++;
    if ({out_a, valid_a, out_b, valid_b} !== {16'h5555, 1'b1, 16'hFFFF, 1'b1}) begin
      bad++; $display("FAIL dual_diff: got a=%h b=%h want 5555 ffff", out_a, out_b);
    end
    ra_a = 2'd3; ra_b = 2'd3;
    step();
    total++;
    if ({out_a, valid_a, out_b, valid_b} !== {16'h0000, 1'b1, 16'h0000, 1'b1}) begin
      bad++; $display("FAIL dual_same: got a=%h b=%h want 0000 0000", out_a, out_b);
    end
    idle();
  endtask
  task automatic test_rdw();
    idle();
    load = 1'b1; waddr = 2'd2; din = 16'h1234; ren_a = 1'b1; ra_a = 2'd2;
    step();
    total++;
    if (out_a !== (BYPASS ? 16'h1234 : 16'hFFFF) || out_a !== eo_a) begin
      bad++; $display("FAIL rdw_same: got %h want %h", out_a, BYPASS ? 16'h1234 : 16'hFFFF);
    end
    idle();
    ren_a = 1'b1; ra_a = 2'd2;
    step();
    total++;
    if (out_a !== 16'h1234) begin
      bad++; $display("FAIL rdw_after: got %h want 1234", out_a);
    end
    idle();
  endtask
  task automatic test_hold();
    idle();
    ren_b = 1'b1; ra_b = 2'd1;
    step();
    total++;
    if (out_b !== 16'h5555 || valid_b !== 1'b1) begin
      bad++; $display("FAIL hold_pre: got %h v=%b want 5555 v=1", out_b, valid_b);
    end
    for (int i = 0; i < 3; i++) begin
      ren_b = 1'b0; ra_b = 2'd1; load = 1'b1; waddr = 2'd1; din = 16'hBEEF;
      step();
      total++;
      if (out_b !== 16'h5555 || valid_b !== 1'b0) begin
        bad++; $display("FAIL hold cyc%0d: got %h v=%b want 5555 v=0", i, out_b, valid_b);
      end
    end
    idle();
    ren_b = 1'b1; ra_b = 2'd1;
    step();
    total++;
    if (out_b !== 16'hBEEF || valid_b !== 1'b1) begin
      bad++; $display("FAIL hold_after: got %h v=%b want beef v=1", out_b, valid_b);
    end
    idle();
  endtask
  task automatic test_mid_reset();
    fill();
    for (int i = 0; i < 2; i++) begin
      ren_a = 1'b1; ra_a = 2'(i);
      step();
    end
    rst_n = 1'b0; ren_a = 1'b1; ra_a = 2'd2; load = 1'b1; waddr = 2'd2; din = 16'h7777;
    step();
    total++;
    if ({out_a, valid_a, out_b, valid_b} !== 34'h0) begin
      bad++; $display("FAIL mid_reset: got a=%h va=%b b=%h vb=%b want all 0", out_a, valid_a, out_b, valid_b);
    end
    idle();
    for (int i = 2; i < 4; i++) begin
      ren_a = 1'b1; ra_a = 2'(i);
      step();
      total++;
      if (out_a !== 16'h0 || valid_a !== 1'b1) begin
        bad++; $display("FAIL mid_resume addr%0d: got %h v=%b want 0000 v=1", i, out_a, valid_a);
      end
    end
    idle();
  endtask
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 29) != 0);
      load = 1'($urandom); waddr = 2'($urandom); din = 16'($urandom);
      ren_a = 1'($urandom); ra_a = 2'($urandom);
      ren_b = 1'($urandom); ra_b = 2'($urandom);
      step();
      total++;
      if ({out_a, valid_a, out_b, valid_b} !== {eo_a, ev_a, eo_b, ev_b}) begin
        bad++; $display("FAIL random cyc%0d: got a=%h va=%b b=%h vb=%b want a=%h va=%b b=%h vb=%b",
          i, out_a, valid_a, out_b, valid_b, eo_a, ev_a, eo_b, ev_b);
      end
    end
    idle();
  endtask
  initial begin
    idle();
    test_reset();
    test_fill_read();
    test_dual_port();
    test_rdw();
    test_hold();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
